// File: rtl/lsu_sram_port.sv
// Data-side load/store unit: one bus transaction at a time, aligned/extended load data, LWL/LWR merge, SC status.
// Latency: resp 3 cycles after accept (best case), 1 cycle on ade/SC-fail/illegal; stalls on addr_ok/data_ok; no resp backpressure.
module lsu_sram_port (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [31:0] in_addr,
   input  logic [3:0]  in_byte_valid,
   input  logic        in_mwe,
   input  logic [31:0] in_rt,
   input  logic        flush,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_ade,
   output logic        resp_is_store
);

   localparam logic [3:0] OP_LB  = 4'd0;
   localparam logic [3:0] OP_LBU = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LHU = 4'd3;
   localparam logic [3:0] OP_LW  = 4'd4;
   localparam logic [3:0] OP_LWL = 4'd5;
   localparam logic [3:0] OP_LWR = 4'd6;
   localparam logic [3:0] OP_LL  = 4'd7;
   localparam logic [3:0] OP_SB  = 4'd8;
   localparam logic [3:0] OP_SH  = 4'd9;
   localparam logic [3:0] OP_SW  = 4'd10;
   localparam logic [3:0] OP_SWL = 4'd11;
   localparam logic [3:0] OP_SWR = 4'd12;
   localparam logic [3:0] OP_SC  = 4'd13;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_RESP  = 3'd4;

   logic [2:0]  state_q;
   logic [3:0]  op_q;
   logic [31:0] addr_q;
   logic [31:0] rt_q;
   logic        req_q;
   logic        resp_q;

   logic        accept;
   logic [1:0]  k_in;
   logic        in_is_store;
   logic        in_illegal;
   logic        in_misaligned;
   logic [1:0]  size_in;
   logic [31:0] baddr_in;
   logic [31:0] wdata_in;

   logic [1:0]  k_q;
   logic        op_q_is_store;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_result;

   assign in_ready = (state_q == ST_IDLE);
   assign accept   = in_valid & in_ready & ~flush;
   assign k_in     = in_addr[1:0];

   // Flush must kill the request and the response in the cycle it is seen.
   assign data_req   = req_q & ~flush;
   assign resp_valid = resp_q & ~flush;

   // Request-side decode of the incoming op.
   always_comb begin
      in_is_store   = (in_op >= OP_SB) && (in_op <= OP_SC);
      in_illegal    = (in_op > OP_SC);
      in_misaligned = 1'b0;
      size_in       = 2'd2;
      baddr_in      = in_addr;
      wdata_in      = 32'd0;
      case (in_op)
         OP_LB, OP_LBU, OP_SB: size_in = 2'd0;
         OP_LH, OP_LHU, OP_SH: begin
            size_in       = 2'd1;
            in_misaligned = in_addr[0];
         end
         OP_LW, OP_LL, OP_SW, OP_SC: in_misaligned = |in_addr[1:0];
         OP_LWL, OP_LWR, OP_SWL, OP_SWR: baddr_in = {in_addr[31:2], 2'b00};
         default: ;
      endcase
      case (in_op)
         OP_SB:        wdata_in = {4{in_rt[7:0]}};
         OP_SH:        wdata_in = {2{in_rt[15:0]}};
         OP_SW, OP_SC: wdata_in = in_rt;
         OP_SWL: begin
            case (k_in)
               2'd0:    wdata_in = {24'd0, in_rt[31:24]};
               2'd1:    wdata_in = {16'd0, in_rt[31:16]};
               2'd2:    wdata_in = {8'd0,  in_rt[31:8]};
               default: wdata_in = in_rt;
            endcase
         end
         OP_SWR: begin
            case (k_in)
               2'd0:    wdata_in = in_rt;
               2'd1:    wdata_in = {in_rt[23:0], 8'd0};
               2'd2:    wdata_in = {in_rt[15:0], 16'd0};
               default: wdata_in = {in_rt[7:0],  24'd0};
            endcase
         end
         default: wdata_in = 32'd0;
      endcase
   end

   // Response-side shaping of the returned bus word.
   assign k_q           = addr_q[1:0];
   assign op_q_is_store = (op_q >= OP_SB) && (op_q <= OP_SC);

   always_comb begin
      case (k_q)
         2'd0:    byte_sel = data_rdata[7:0];
         2'd1:    byte_sel = data_rdata[15:8];
         2'd2:    byte_sel = data_rdata[23:16];
         default: byte_sel = data_rdata[31:24];
      endcase
      half_sel    = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
      load_result = data_rdata;
      case (op_q)
         OP_LB:  load_result = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU: load_result = {24'd0, byte_sel};
         OP_LH:  load_result = {{16{half_sel[15]}}, half_sel};
         OP_LHU: load_result = {16'd0, half_sel};
         OP_LW, OP_LL: load_result = data_rdata;
         OP_LWL: begin
            case (k_q)
               2'd0:    load_result = {data_rdata[7:0],  rt_q[23:0]};
               2'd1:    load_result = {data_rdata[15:0], rt_q[15:0]};
               2'd2:    load_result = {data_rdata[23:0], rt_q[7:0]};
               default: load_result = data_rdata;
            endcase
         end
         OP_LWR: begin
            case (k_q)
               2'd0:    load_result = data_rdata;
               2'd1:    load_result = {rt_q[31:24], data_rdata[31:8]};
               2'd2:    load_result = {rt_q[31:16], data_rdata[31:16]};
               default: load_result = {rt_q[31:8],  data_rdata[31:24]};
            endcase
         end
         OP_SC:   load_result = 32'd1;
         default: load_result = 32'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         op_q          <= 4'd0;
         addr_q        <= 32'd0;
         rt_q          <= 32'd0;
         req_q         <= 1'b0;
         resp_q        <= 1'b0;
         data_wr       <= 1'b0;
         data_size     <= 2'd0;
         data_addr     <= 32'd0;
         data_wstrb    <= 4'd0;
         data_wdata    <= 32'd0;
         resp_rdata    <= 32'd0;
         resp_ade      <= 1'b0;
         resp_is_store <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q          <= in_op;
                  addr_q        <= in_addr;
                  rt_q          <= in_rt;
                  resp_rdata    <= 32'd0;
                  resp_ade      <= 1'b0;
                  resp_is_store <= in_is_store;
                  if (in_illegal) begin
                     resp_is_store <= 1'b0;
                     resp_q        <= 1'b1;
                     state_q       <= ST_RESP;
                  end else if (in_misaligned) begin
                     resp_ade <= 1'b1;
                     resp_q   <= 1'b1;
                     state_q  <= ST_RESP;
                  end else if ((in_op == OP_SC) && !in_mwe) begin
                     resp_q  <= 1'b1;
                     state_q <= ST_RESP;
                  end else begin
                     req_q      <= 1'b1;
                     data_wr    <= in_is_store;
                     data_size  <= size_in;
                     data_addr  <= baddr_in;
                     data_wstrb <= in_is_store ? in_byte_valid : 4'd0;
                     data_wdata <= wdata_in;
                     state_q    <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               // data_ok here belongs to nobody; only addr_ok is looked at.
               if (flush) begin
                  req_q   <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (data_addr_ok) begin
                  req_q   <= 1'b0;
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (data_data_ok) begin
                  if (flush) begin
                     state_q <= ST_IDLE;
                  end else begin
                     resp_rdata    <= load_result;
                     resp_ade      <= 1'b0;
                     resp_is_store <= op_q_is_store;
                     resp_q        <= 1'b1;
                     state_q       <= ST_RESP;
                  end
               end else if (flush) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (data_data_ok) state_q <= ST_IDLE;
            end
            ST_RESP: begin
               resp_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               req_q   <= 1'b0;
               resp_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_sram_port.sv
// Directed bench for lsu_sram_port: hand-computed loads/stores, fast paths, stalls and flushes.
module tb_lsu_sram_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [31:0] in_addr;
   logic [3:0]  in_byte_valid;
   logic        in_mwe;
   logic [31:0] in_rt;
   logic        flush;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_ade;
   logic        resp_is_store;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lsu_sram_port dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
      .in_byte_valid(in_byte_valid), .in_mwe(in_mwe), .in_rt(in_rt), .flush(flush),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_ade(resp_ade),
      .resp_is_store(resp_is_store)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one op for one cycle; returns in the cycle after acceptance.
   task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [3:0] bv,
                        input logic mwe, input logic [31:0] rt);
      in_valid = 1'b1; in_op = op; in_addr = addr; in_byte_valid = bv; in_mwe = mwe; in_rt = rt;
      step();
      in_valid = 1'b0;
   endtask

   // From REQ: addr_ok now, data_ok next cycle; returns in the RESP cycle.
   task automatic bus_xfer(input logic [31:0] rd);
      data_addr_ok = 1'b1;
      step();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b1;
      data_rdata   = rd;
      step();
      data_data_ok = 1'b0;
   endtask

   task automatic load_case(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] exp);
      issue(op, addr, 4'b0000, 1'b1, rt);
      chk({tag, ".req"}, 32'(data_req), 32'd1);
      chk({tag, ".wr"}, 32'(data_wr), 32'd0);
      bus_xfer(rd);
      chk({tag, ".vld"}, 32'(resp_valid), 32'd1);
      chk({tag, ".rdata"}, resp_rdata, exp);
      step();
      chk({tag, ".vld_off"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_addr = 32'd0; in_byte_valid = 4'd0;
      in_mwe = 1'b0; in_rt = 32'd0; flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
      data_rdata = 32'd0;
      step(); step();
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.req", 32'(data_req), 32'd0);
      chk("rst.addr", data_addr, 32'd0);
      chk("rst.wdata", data_wdata, 32'd0);
      chk("rst.resp_vld", 32'(resp_valid), 32'd0);
      chk("rst.resp_rdata", resp_rdata, 32'd0);
      rst = 1'b0;
      step();

      // LB / LBU at 0x1003: lane 3 = 0x80
      issue(4'd0, 32'h0000_1003, 4'b0000, 1'b1, 32'd0);
      chk("lb.size", 32'(data_size), 32'd0);
      chk("lb.addr", data_addr, 32'h0000_1003);
      chk("lb.wstrb", 32'(data_wstrb), 32'd0);
      bus_xfer(32'h8011_2233);
      chk("lb.vld", 32'(resp_valid), 32'd1);
      chk("lb.rdata", resp_rdata, 32'hFFFF_FF80);
      chk("lb.ade", 32'(resp_ade), 32'd0);
      step();
      load_case("lbu", 4'd1, 32'h0000_1003, 32'd0, 32'h8011_2233, 32'h0000_0080);

      // SWL at 0x2001 (k=1): rt >> 16
      issue(4'd11, 32'h0000_2001, 4'b0011, 1'b1, 32'hAABB_CCDD);
      chk("swl.req", 32'(data_req), 32'd1);
      chk("swl.wr", 32'(data_wr), 32'd1);
      chk("swl.size", 32'(data_size), 32'd2);
      chk("swl.addr", data_addr, 32'h0000_2000);
      chk("swl.wstrb", 32'(data_wstrb), 32'h3);
      chk("swl.wdata", data_wdata, 32'h0000_AABB);
      bus_xfer(32'd0);
      chk("swl.vld", 32'(resp_valid), 32'd1);
      step();

      load_case("lwr", 4'd6, 32'h0000_2002, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122);
      load_case("lwl", 4'd5, 32'h0000_2001, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD);

      // Misaligned LW: fast AdEL, no bus
      issue(4'd4, 32'h0000_3002, 4'b0000, 1'b1, 32'd0);
      chk("lw_ade.req", 32'(data_req), 32'd0);
      chk("lw_ade.vld", 32'(resp_valid), 32'd1);
      chk("lw_ade.ade", 32'(resp_ade), 32'd1);
      chk("lw_ade.kind", 32'(resp_is_store), 32'd0);
      step();
      chk("lw_ade.ready", 32'(in_ready), 32'd1);

      // Misaligned SH: AdES
      issue(4'd9, 32'h0000_4001, 4'b0011, 1'b1, 32'd0);
      chk("sh_ade.ade", 32'(resp_ade), 32'd1);
      chk("sh_ade.kind", 32'(resp_is_store), 32'd1);
      step();

      // SC fail and success
      issue(4'd13, 32'h0000_4000, 4'b1111, 1'b0, 32'h1234_5678);
      chk("scf.req", 32'(data_req), 32'd0);
      chk("scf.vld", 32'(resp_valid), 32'd1);
      chk("scf.rdata", resp_rdata, 32'd0);
      step();
      issue(4'd13, 32'h0000_4000, 4'b1111, 1'b1, 32'h1234_5678);
      chk("sc.wr", 32'(data_wr), 32'd1);
      chk("sc.wdata", data_wdata, 32'h1234_5678);
      chk("sc.wstrb", 32'(data_wstrb), 32'hF);
      bus_xfer(32'hDEAD_BEEF);
      chk("sc.rdata", resp_rdata, 32'd1);
      step();

      // Illegal op
      issue(4'd14, 32'h0000_5000, 4'b0000, 1'b1, 32'hFFFF_FFFF);
      chk("ill.vld", 32'(resp_valid), 32'd1);
      chk("ill.ade", 32'(resp_ade), 32'd0);
      chk("ill.rdata", resp_rdata, 32'd0);
      step();

      // SB replicate, then addr_ok stall for 5 cycles
      issue(4'd8, 32'h0000_5002, 4'b0100, 1'b1, 32'h0000_00A5);
      for (int i = 0; i < 5; i++) begin
         chk("stall.req", 32'(data_req), 32'd1);
         chk("stall.addr", data_addr, 32'h0000_5002);
         chk("stall.wdata", data_wdata, 32'hA5A5_A5A5);
         chk("stall.wstrb", 32'(data_wstrb), 32'h4);
         chk("stall.size", 32'(data_size), 32'd0);
         step();
      end
      bus_xfer(32'd0);
      chk("stall.vld", 32'(resp_valid), 32'd1);
      step();

      // LH with a stray data_ok coincident with addr_ok in REQ: must be ignored
      issue(4'd2, 32'h0000_6002, 4'b0000, 1'b1, 32'd0);
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0000_0000;
      step();
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      chk("lh.early_vld", 32'(resp_valid), 32'd0);
      step();
      chk("lh.wait_vld", 32'(resp_valid), 32'd0);
      data_data_ok = 1'b1; data_rdata = 32'h8001_1234;
      step();
      data_data_ok = 1'b0;
      chk("lh.vld", 32'(resp_valid), 32'd1);
      chk("lh.rdata", resp_rdata, 32'hFFFF_8001);
      step();

      // Flush in WAIT, data_ok three cycles later
      issue(4'd4, 32'h0000_7000, 4'b0000, 1'b1, 32'd0);
      data_addr_ok = 1'b1;
      step();
      data_addr_ok = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("drain.vld1", 32'(resp_valid), 32'd0);
      chk("drain.ready1", 32'(in_ready), 32'd0);
      step();
      step();
      data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
      chk("drain.ready3", 32'(in_ready), 32'd0);
      step();
      data_data_ok = 1'b0;
      chk("drain.ready", 32'(in_ready), 32'd1);
      chk("drain.vld", 32'(resp_valid), 32'd0);

      // Flush in REQ drops data_req in the same cycle
      issue(4'd4, 32'h0000_7004, 4'b0000, 1'b1, 32'd0);
      flush = 1'b1;
      #1;
      chk("freq.req", 32'(data_req), 32'd0);
      step();
      flush = 1'b0;
      chk("freq.ready", 32'(in_ready), 32'd1);
      chk("freq.req_after", 32'(data_req), 32'd0);

      // Flush in IDLE blocks acceptance
      flush = 1'b1;
      issue(4'd4, 32'h0000_8000, 4'b0000, 1'b1, 32'd0);
      flush = 1'b0;
      chk("fidle.ready", 32'(in_ready), 32'd1);
      chk("fidle.req", 32'(data_req), 32'd0);
      chk("fidle.vld", 32'(resp_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lsu_sram_port.md
# lsu_sram_port

Memory-side load/store unit for the data SRAM-like bus. It consumes the effective address, byte-lane mask and store-enable produced by the EXE-stage ALU. It issues one bus transaction at a time, then returns aligned, sign- or zero-extended load data (including LWL/LWR merge) or the SC status to the MEM/WB pipeline. It sits between the EXE/MEM pipeline register and the data-side bus bridge.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  memory op presented
- in_ready  out  1  unit can accept (1 only in IDLE)
- in_op  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 7 LL, 8 SB, 9 SH, 10 SW, 11 SWL, 12 SWR, 13 SC; 14–15 illegal
- in_addr  in  32  effective address (ALU result_sum)
- in_byte_valid  in  4  lane mask from ALU
- in_mwe  in  1  store permitted (0 = SC fails)
- in_rt  in  32  rt value: store data, or old rt for LWL/LWR merge
- flush  in  1  exception/eret flush from COP0
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  bus address
- data_wstrb  out  4  write byte strobes
- data_wdata  out  32  lane-aligned write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write done
- data_rdata  in  32  read data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result, or SC status (1/0)
- resp_ade  out  1  address error; qualified by resp_valid
- resp_is_store  out  1  ade kind: 1 = AdES, 0 = AdEL

## Operation
- FSM states: IDLE, REQ, WAIT, DRAIN, RESP.
- Accept occurs when in_valid & in_ready & !flush. All inputs are registered on accept.
- Alignment check on accept:
  - LH/LHU/SH require addr[0]=0.
  - LW/LL/SW/SC require addr[1:0]=0.
  - Failure: go to RESP, resp_ade=1, no bus activity.
- Illegal op (14–15): go to RESP with ade=0, rdata=0.
- SC with in_mwe=0: go to RESP, rdata=0, no bus activity.
- Every other op goes to REQ.
- REQ: data_req=1 and hold all bus fields stable until data_addr_ok. On addr_ok, go to WAIT.
- WAIT: on data_data_ok, capture data_rdata, form the result, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Bus field formation (k = addr[1:0]):
  - Byte/half ops: data_addr = addr; size 0/1.
  - LW/LL/SW/SC: data_addr = addr; size 2.
  - LWL/LWR/SWL/SWR: data_addr = {addr[31:2],2'b00}; size 2.
  - data_wstrb = in_byte_valid for stores, 0 for loads.
  - Write data: SB replicates rt[7:0] to all lanes; SH replicates rt[15:0]; SW/SC pass rt; SWL = rt >> 8*(3-k); SWR = rt << 8*k.
- Load data formation:
  - LB/LBU: select lane k; LH/LHU: select half addr[1]; sign- or zero-extend.
  - LW/LL: rdata unchanged.
  - LWL: (rdata << 8*(3-k)) | (rt & (32'hFFFFFFFF >> 8*(k+1))), taking 0 when k=3.
  - LWR: (rdata >> 8*k) | (rt & ~(32'hFFFFFFFF >> 8*k)).
  - Successful SC: resp_rdata=1.
- Flush handling:
  - IDLE: flush blocks acceptance.
  - REQ: drop data_req in the same cycle and return to IDLE.
  - WAIT: go to DRAIN, absorb the pending data_ok, no resp_valid, then IDLE.
  - RESP: suppress resp_valid and return to IDLE.

## Timing
- Reset: state IDLE; in_ready=1; data_req=0, data_wr=0, data_size=0, data_addr=0, data_wstrb=0, data_wdata=0; resp_valid=0, resp_rdata=0, resp_ade=0, resp_is_store=0.
- Bus outputs and resp_* are registered. in_ready is decoded from state.
- Best-case latency: accept at cycle t, data_req at t+1 with addr_ok at t+1, data_ok at t+2, resp_valid at t+3.
- Fast paths (ade / SC fail / illegal): resp_valid at t+1.
- data_ok is honoured only in WAIT/DRAIN; it is ignored in REQ even if coincident with addr_ok.
- Reset mid-transaction returns to IDLE immediately. Any late data_ok is ignored.
- One outstanding transaction; no response backpressure.

## Test plan
- LB at addr 0x1003, bus rdata 0x80112233: resp_rdata 0xFFFFFF80. LBU at the same address gives 0x00000080. Both have data_size 0 and data_addr 0x1003.
- SWL at addr 0x2001, rt 0xAABBCCDD: data_addr 0x2000, wstrb 0011, wdata low half 0xAABB.
- LWR at addr 0x2002, rdata 0x11223344, rt 0xAABBCCDD: resp_rdata 0xAABB1122.
- LW at 0x3002: no data_req; resp_valid at t+1 with resp_ade=1, resp_is_store=0. SC with in_mwe=0: no bus activity, resp_rdata 0.
- addr_ok held low 5 cycles: all bus fields stable throughout; resp_valid occurs 2 cycles after addr_ok given data_ok 1 cycle after.
- flush asserted in WAIT, data_ok arrives 3 cycles later: no resp_valid; in_ready returns 1 the cycle after data_ok.
